param_alu_unit: RTL
===================

Name: param_alu_unit

Overview:
Parametrised, handshaked successor to the team's fixed 16-bit ALU DUT. It accepts two unsigned WIDTH-bit operands plus a mode, and produces a RES_WIDTH-bit result and a `correct` flag. ADD and SUB are single-cycle. MUL uses an iterative shift-add datapath and DIV a restoring-division datapath, each taking WIDTH iterations. Valid/ready handshakes on both sides let the bench driver and scoreboard apply backpressure.

Parameters:
WIDTH, 16, operand width in bits (>=2)
RES_WIDTH, 2*WIDTH, result width (fixed at 2*WIDTH; a parameter for interface typing only)
CNT_WIDTH, $clog2(WIDTH+1), iteration counter width

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand/mode presented
in_ready  output  1  unit can accept an operation
value1  input  WIDTH  operand A (unsigned)
value2  input  WIDTH  operand B (unsigned)
mode  input  2  00=ADD, 01=SUB, 10=MUL, 11=DIV
out_valid  output  1  result/correct are valid
out_ready  input  1  consumer accepts the result
result  output  RES_WIDTH  operation result
correct  output  1  1 = result arithmetically exact / legal
busy  output  1  1 while an operation is in flight (state != IDLE)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out_valid=0, result=0, correct=0, busy=0; counter and operand registers cleared.
  - in_ready=1, because it is decoded from IDLE. in_valid must be 0 while reset is asserted.
  - A reset mid-operation aborts it; no result is emitted.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); busy = (state!=IDLE); out_valid = (state==DONE).
- Accept: in_valid && in_ready at edge N. value1, value2 and mode are latched; later input changes are ignored.
  - ADD, SUB, or DIV with value2==0: result computed at edge N, go to DONE; out_valid=1 from cycle N+1.
  - MUL, or DIV with value2!=0: go to BUSY, counter=0. Exactly one iteration per cycle for WIDTH cycles, then DONE; out_valid=1 from cycle N+WIDTH+1.
- Arithmetic (operands zero-extended to RES_WIDTH):
  - ADD: result = A+B; correct=1.
  - SUB: result = (A-B) mod 2^RES_WIDTH; correct = (A>=B).
  - MUL: result = A*B, exact; correct=1. Iterative: test LSB of shifting multiplier, add shifted multiplicand.
  - DIV, B!=0: result[WIDTH-1:0] = quotient, result[RES_WIDTH-1:WIDTH] = remainder; correct=1. Restoring algorithm, one quotient bit per cycle, MSB first.
  - DIV, B==0: result = all ones; correct=0.
- DONE:
  - result and correct are held stable while out_valid && !out_ready.
  - On out_valid && out_ready at edge M: state goes to IDLE; out_valid=0 and in_ready=1 from cycle M+1.
  - No same-cycle accept-and-return; maximum throughput is one op per 2 cycles (ADD/SUB).
- BUSY/DONE: in_valid is ignored (in_ready=0); no input is captured.
- result and correct keep their last value after leaving DONE until the next completion. Consumers must qualify with out_valid.
- Boundaries:
  - A=B=0 in MUL still takes WIDTH cycles.
  - Counter runs 0..WIDTH-1, then exits; no wrap.
  - Max operands never overflow RES_WIDTH.

Test Plan:
1. WIDTH=16, ADD 0xFFFF+0x0001 accepted at cycle N -> out_valid at N+1, result=0x0001_0000, correct=1. Then SUB 0x0005-0x0003 -> result=0x0000_0002, correct=1.
2. SUB 0x0003-0x0005 -> result=0xFFFF_FFFE, correct=0.
3. MUL 0xFFFF*0xFFFF accepted at N -> busy=1 and in_ready=0 over N+1..N+16; out_valid at N+17; result=0xFFFE_0001, correct=1.
4. DIV 100/7 -> out_valid at N+17, result=0x0002_000E, correct=1. DIV 0x1234/0 -> out_valid at N+1, result=0xFFFF_FFFF, correct=0.
5. Backpressure: DIV 100/7 completes, out_ready=0 for 10 cycles while value1/value2/in_valid toggle -> result stays 0x0002_000E, in_ready=0, nothing captured. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
6. Reset mid-MUL: reset=0 at iteration 5, asynchronously -> out_valid=0, busy=0, result=0 immediately. After release, ADD 2+3 -> result=5, correct=1.

Source files
------------

// File: rtl/param_alu_unit.sv
// -----------------------------------------------------------------------------
// param_alu_unit
//
// Parametrised ALU with valid/ready handshakes on both sides. ADD, SUB and
// divide-by-zero complete in one cycle. MUL (shift-add) and DIV (restoring,
// quotient MSB first) run one iteration per cycle for WIDTH cycles.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   operands/mode presented
//   in_ready   unit is idle and can accept an operation
//   value1     operand A (unsigned)
//   value2     operand B (unsigned)
//   mode       00=ADD, 01=SUB, 10=MUL, 11=DIV
//   out_valid  result/correct are valid
//   out_ready  consumer accepts the result
//   result     ADD/SUB/MUL: arithmetic result; DIV: {remainder, quotient}
//   correct    1 = result exact / legal (SUB without borrow, DIV with B!=0)
//   busy       an operation is in flight
// -----------------------------------------------------------------------------
module param_alu_unit #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 2 * WIDTH,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     value1,
  input  logic [WIDTH-1:0]     value2,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] result,
  output logic                 correct,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WIDTH - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div;

  // Multiplier datapath: accumulator, left-shifting multiplicand and
  // right-shifting multiplier whose LSB selects each partial product.
  logic [RES_WIDTH-1:0] acc;
  logic [RES_WIDTH-1:0] mcand;
  logic [WIDTH-1:0]     mplier;

  // Divider datapath: partial remainder, and a register that starts as the
  // dividend and fills with quotient bits from the right as it shifts left.
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;

  logic [RES_WIDTH-1:0] a_ext;
  logic [RES_WIDTH-1:0] b_ext;
  logic [RES_WIDTH-1:0] fast_result;
  logic                 fast_correct;
  logic                 go_long;

  logic [RES_WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_rem_next;
  logic [WIDTH-1:0]     div_quo_next;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign a_ext = {{(RES_WIDTH - WIDTH){1'b0}}, value1};
  assign b_ext = {{(RES_WIDTH - WIDTH){1'b0}}, value2};

  assign go_long = (mode == MODE_MUL) || ((mode == MODE_DIV) && (value2 != '0));

  // Single-cycle results, taken straight from the input operands at accept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    fast_result  = '0;
    fast_correct = 1'b0;
    case (mode)
      MODE_ADD: begin
        fast_result  = a_ext + b_ext;
        fast_correct = 1'b1;
      end
      MODE_SUB: begin
        fast_result  = a_ext - b_ext;
        fast_correct = (value1 >= value2);
      end
      MODE_DIV: begin
        fast_result  = '1;
        fast_correct = 1'b0;
      end
      default: ;
    endcase
  end

  // One iteration of each iterative datapath.
  always_comb begin
    mul_acc_next = mplier[0] ? (acc + mcand) : acc;

    // Bring the next dividend bit into the partial remainder and try to
    // subtract the divisor; a clear sign bit means the subtraction fits.
    // The shifted remainder is below 2*divisor, so a fitting trial always
    // fits back into WIDTH bits.
    div_shift    = {rem, quo[WIDTH-1]};
    div_trial    = div_shift - {1'b0, divisor};
    div_fits     = ~div_trial[WIDTH];
    div_rem_next = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_next = {quo[WIDTH-2:0], div_fits};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state   <= ST_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      result  <= '0;
      correct <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (go_long) begin
              cnt   <= '0;
              state <= ST_BUSY;
              if (mode == MODE_MUL) begin
                is_div <= 1'b0;
                acc    <= '0;
                mcand  <= a_ext;
                mplier <= value2;
              end else begin
                is_div  <= 1'b1;
                rem     <= '0;
                quo     <= value1;
                divisor <= value2;
              end
            end else begin
              result  <= fast_result;
              correct <= fast_correct;
              state   <= ST_DONE;
            end
          end
        end

        ST_BUSY: begin
          if (is_div) begin
            rem <= div_rem_next;
            quo <= div_quo_next;
          end else begin
            acc    <= mul_acc_next;
            mcand  <= {mcand[RES_WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
          end

          // The final iteration publishes its own next-state values directly,
          // so DONE follows the WIDTH-th iteration with no extra cycle.
          if (cnt == LAST_ITER) begin
            result  <= is_div ? {div_rem_next, div_quo_next} : mul_acc_next;
            correct <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
